// File: rtl/bsg_rocket_pkg.sv
// rtl/bsg_rocket_pkg.sv - NASTI tap packet types, trace record type and per-channel pack functions
// BSG_ROCKET_NASTI_TRACE_DATA_EN adds data[31:0] to W and R payloads.
package bsg_rocket_pkg;

    localparam int bsg_nasti_id_width_gp   = 5;
    localparam int bsg_nasti_addr_width_gp = 32;
    localparam int bsg_nasti_len_width_gp  = 8;
    localparam int bsg_nasti_data_width_gp = 64;
    localparam int bsg_nasti_strb_width_gp = 8;
    localparam int bsg_nasti_resp_width_gp = 2;

    typedef struct packed {
        logic [bsg_nasti_id_width_gp-1:0]   id;
        logic [bsg_nasti_addr_width_gp-1:0] addr;
        logic [bsg_nasti_len_width_gp-1:0]  len;
    } bsg_nasti_a_pkt;

    typedef struct packed {
        logic [bsg_nasti_data_width_gp-1:0] data;
        logic [bsg_nasti_strb_width_gp-1:0] strb;
        logic                               last;
    } bsg_nasti_w_pkt;

    typedef struct packed {
        logic [bsg_nasti_id_width_gp-1:0]   id;
        logic [bsg_nasti_resp_width_gp-1:0] resp;
    } bsg_nasti_b_pkt;

    typedef struct packed {
        logic [bsg_nasti_id_width_gp-1:0]   id;
        logic [bsg_nasti_resp_width_gp-1:0] resp;
        logic [bsg_nasti_data_width_gp-1:0] data;
        logic                               last;
    } bsg_nasti_r_pkt;

    typedef enum logic [2:0] {
        bsg_rocket_trace_chan_aw_e = 3'd0,
        bsg_rocket_trace_chan_w_e  = 3'd1,
        bsg_rocket_trace_chan_b_e  = 3'd2,
        bsg_rocket_trace_chan_ar_e = 3'd3,
        bsg_rocket_trace_chan_r_e  = 3'd4
    } bsg_rocket_trace_chan_e;

    localparam int bsg_rocket_trace_chans_gp    = 5;
    localparam int bsg_rocket_trace_ts_width_gp = 16;

`ifdef BSG_ROCKET_NASTI_TRACE_DATA_EN
    localparam int bsg_rocket_trace_capt_width_gp = 32;
`else
    localparam int bsg_rocket_trace_capt_width_gp = 0;
`endif

    localparam int bsg_rocket_trace_a_width_gp = bsg_nasti_id_width_gp + bsg_nasti_addr_width_gp
                                               + bsg_nasti_len_width_gp;
    localparam int bsg_rocket_trace_w_width_gp = bsg_nasti_strb_width_gp + 1
                                               + bsg_rocket_trace_capt_width_gp;
    localparam int bsg_rocket_trace_b_width_gp = bsg_nasti_id_width_gp + bsg_nasti_resp_width_gp;
    localparam int bsg_rocket_trace_r_width_gp = bsg_nasti_id_width_gp + bsg_nasti_resp_width_gp + 1
                                               + bsg_rocket_trace_capt_width_gp;

    function automatic int bsg_rocket_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int bsg_rocket_trace_payload_width_gp =
        bsg_rocket_max(bsg_rocket_max(bsg_rocket_trace_a_width_gp, bsg_rocket_trace_w_width_gp),
                       bsg_rocket_max(bsg_rocket_trace_b_width_gp, bsg_rocket_trace_r_width_gp));

    typedef logic [bsg_rocket_trace_payload_width_gp-1:0] bsg_rocket_trace_payload_t;

    typedef struct packed {
        logic [bsg_rocket_trace_ts_width_gp-1:0] ts;
        bsg_rocket_trace_chan_e                  chan;
        bsg_rocket_trace_payload_t               payload;
    } bsg_rocket_trace_rec_t;

    // Payloads are LSB-aligned with the unused upper bits left zero.
    function automatic bsg_rocket_trace_payload_t bsg_rocket_trace_pack_a(input bsg_nasti_a_pkt a);
        bsg_rocket_trace_payload_t p;
        p = '0;
        p[bsg_rocket_trace_a_width_gp-1:0] = {a.id, a.addr, a.len};
        return p;
    endfunction

    function automatic bsg_rocket_trace_payload_t bsg_rocket_trace_pack_w(input bsg_nasti_w_pkt w);
        bsg_rocket_trace_payload_t p;
        p = '0;
`ifdef BSG_ROCKET_NASTI_TRACE_DATA_EN
        p[bsg_rocket_trace_w_width_gp-1:0] = {w.data[31:0], w.strb, w.last};
`else
        p[bsg_rocket_trace_w_width_gp-1:0] = {w.strb, w.last};
`endif
        return p;
    endfunction

    function automatic bsg_rocket_trace_payload_t bsg_rocket_trace_pack_b(input bsg_nasti_b_pkt b);
        bsg_rocket_trace_payload_t p;
        p = '0;
        p[bsg_rocket_trace_b_width_gp-1:0] = {b.id, b.resp};
        return p;
    endfunction

    function automatic bsg_rocket_trace_payload_t bsg_rocket_trace_pack_r(input bsg_nasti_r_pkt r);
        bsg_rocket_trace_payload_t p;
        p = '0;
`ifdef BSG_ROCKET_NASTI_TRACE_DATA_EN
        p[bsg_rocket_trace_r_width_gp-1:0] = {r.data[31:0], r.id, r.resp, r.last};
`else
        p[bsg_rocket_trace_r_width_gp-1:0] = {r.id, r.resp, r.last};
`endif
        return p;
    endfunction

endpackage

// File: rtl/bsg_rocket_nasti_trace_fifo.sv
// rtl/bsg_rocket_nasti_trace_fifo.sv - 1r1w record FIFO with registered full/empty flags
module bsg_rocket_nasti_trace_fifo #(
    parameter int els_p   = 8,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w = $clog2(els_p);

    logic [width_p-1:0] r_mem [els_p];
    logic [ptr_w-1:0]   r_wptr, r_rptr;
    logic               r_full, r_empty;
    logic               w_push, w_pop;
    logic [ptr_w-1:0]   w_wptr_inc, w_rptr_inc;

    assign w_push     = v_i & ~r_full;
    assign w_pop      = yumi_i & ~r_empty;
    assign w_wptr_inc = r_wptr + ptr_w'(1);
    assign w_rptr_inc = r_rptr + ptr_w'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= w_wptr_inc;
            if (w_pop)  r_rptr <= w_rptr_inc;
            // Simultaneous push and pop leave occupancy, and so both flags, unchanged.
            if (w_push && !w_pop) begin
                r_empty <= 1'b0;
                r_full  <= (w_wptr_inc == r_rptr);
            end else if (w_pop && !w_push) begin
                r_full  <= 1'b0;
                r_empty <= (w_rptr_inc == r_wptr);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

    assign full_o = r_full;
    assign v_o    = ~r_empty;
    assign data_o = r_mem[r_rptr];

endmodule

// File: rtl/bsg_rocket_nasti_trace.sv
// rtl/bsg_rocket_nasti_trace.sv - passive NASTI handshake trace capture with round-robin drain FIFO
// BSG_ROCKET_NASTI_TRACE_DATA_EN (in bsg_rocket_pkg) widens W/R payloads with data[31:0].
module bsg_rocket_nasti_trace
    import bsg_rocket_pkg::*;
#(
    parameter int els_p        = 8,
    parameter int ts_width_p   = 16,
    parameter int drop_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    aw_valid_i,
    input  logic                    aw_ready_i,
    input  bsg_nasti_a_pkt          aw_data_i,
    input  logic                    w_valid_i,
    input  logic                    w_ready_i,
    input  bsg_nasti_w_pkt          w_data_i,
    input  logic                    b_valid_i,
    input  logic                    b_ready_i,
    input  bsg_nasti_b_pkt          b_data_i,
    input  logic                    ar_valid_i,
    input  logic                    ar_ready_i,
    input  bsg_nasti_a_pkt          ar_data_i,
    input  logic                    r_valid_i,
    input  logic                    r_ready_i,
    input  bsg_nasti_r_pkt          r_data_i,
    output logic                    trace_v_o,
    output bsg_rocket_trace_rec_t   trace_data_o,
    input  logic                    trace_ready_i,
    output logic [drop_width_p-1:0] drop_count_o
);
    localparam int nc    = bsg_rocket_trace_chans_gp;
    localparam int sum_w = drop_width_p + 3;
    localparam int rec_w = $bits(bsg_rocket_trace_rec_t);

    logic [nc-1:0]             w_fire, w_load, w_drop, w_grant;
    bsg_rocket_trace_payload_t w_payload [nc];
    bsg_rocket_trace_rec_t     w_new_rec [nc];
    bsg_rocket_trace_rec_t     w_push_rec;
    logic [bsg_rocket_trace_ts_width_gp-1:0] w_ts_ext;
    logic                      w_found, w_push, w_fifo_full, w_fifo_v;
    logic [2:0]                w_grant_idx, w_drop_n;
    logic [sum_w-1:0]          w_drop_sum;
    logic [drop_width_p-1:0]   w_drop_next;
    logic [rec_w-1:0]          w_fifo_data;

    logic [nc-1:0]             r_hold_v;
    bsg_rocket_trace_rec_t     r_hold_rec [nc];
    logic [ts_width_p-1:0]     r_ts;
    logic [2:0]                r_last;
    logic [drop_width_p-1:0]   r_drop;

    assign w_fire = {r_valid_i, ar_valid_i, b_valid_i, w_valid_i, aw_valid_i}
                  & {r_ready_i, ar_ready_i, b_ready_i, w_ready_i, aw_ready_i}
                  & {nc{en_i & ~reset_i}};

    assign w_payload[0] = bsg_rocket_trace_pack_a(aw_data_i);
    assign w_payload[1] = bsg_rocket_trace_pack_w(w_data_i);
    assign w_payload[2] = bsg_rocket_trace_pack_b(b_data_i);
    assign w_payload[3] = bsg_rocket_trace_pack_a(ar_data_i);
    assign w_payload[4] = bsg_rocket_trace_pack_r(r_data_i);

    always_comb begin
        w_ts_ext = '0;
        w_ts_ext[ts_width_p-1:0] = r_ts;
        for (int c = 0; c < nc; c++) begin
            w_new_rec[c].ts      = w_ts_ext;
            w_new_rec[c].chan    = bsg_rocket_trace_chan_e'(3'(c));
            w_new_rec[c].payload = w_payload[c];
        end
    end

    // Round-robin search begins one past the last granted channel.
    always_comb begin
        int k;
        w_found     = 1'b0;
        w_grant_idx = r_last;
        for (int i = 1; i <= nc; i++) begin
            k = (int'(r_last) + i) % nc;
            if (!w_found && r_hold_v[k]) begin
                w_found     = 1'b1;
                w_grant_idx = 3'(k);
            end
        end
        w_push     = w_found & ~w_fifo_full;
        w_grant    = '0;
        w_push_rec = '0;
        for (int c = 0; c < nc; c++) begin
            if (w_push && (w_grant_idx == 3'(c))) begin
                w_grant[c] = 1'b1;
                w_push_rec = r_hold_rec[c];
            end
        end
    end

    assign w_load = w_fire & (~r_hold_v | w_grant);
    assign w_drop = w_fire & ~w_load;

    always_comb begin
        w_drop_n = '0;
        for (int c = 0; c < nc; c++) w_drop_n = w_drop_n + {2'b00, w_drop[c]};
        w_drop_sum  = {3'b000, r_drop} + {{drop_width_p{1'b0}}, w_drop_n};
        w_drop_next = (|w_drop_sum[sum_w-1:drop_width_p]) ? '1 : w_drop_sum[drop_width_p-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ts     <= '0;
            r_last   <= 3'(nc - 1);
            r_drop   <= '0;
            r_hold_v <= '0;
        end else begin
            r_ts   <= r_ts + ts_width_p'(1);
            r_drop <= w_drop_next;
            if (w_push) r_last <= w_grant_idx;
            for (int c = 0; c < nc; c++) begin
                if (w_load[c])       r_hold_v[c] <= 1'b1;
                else if (w_grant[c]) r_hold_v[c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < nc; c++) begin
            if (w_load[c]) r_hold_rec[c] <= w_new_rec[c];
        end
    end

    bsg_rocket_nasti_trace_fifo #(
        .els_p   (els_p),
        .width_p (rec_w)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_push),
        .data_i  (w_push_rec),
        .full_o  (w_fifo_full),
        .v_o     (w_fifo_v),
        .data_o  (w_fifo_data),
        .yumi_i  (trace_ready_i)
    );

    assign trace_v_o    = w_fifo_v;
    assign trace_data_o = bsg_rocket_trace_rec_t'(w_fifo_data);
    assign drop_count_o = r_drop;

endmodule
